// File: rtl/avg_pool_layer.sv
// 2x2 stride-2 pooling over a raster stream of square feature maps, one map at a time.
// Define POOL_MAX_EN to build max pooling; the default build averages each window.
module avg_pool_layer #(
  parameter int DATA_W  = 16,
  parameter int MAX_IMG = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [15:0]       imgSize,
  input  logic [15:0]       mapsNumber,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              done
);

  localparam int LB_N  = (MAX_IMG / 2 < 2) ? 2 : MAX_IMG / 2;
  localparam int IDX_W = $clog2(LB_N);
`ifdef POOL_MAX_EN
  localparam int LB_W = DATA_W;
`else
  localparam int LB_W = DATA_W + 1;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state_q;
  logic [15:0]              img_q, maps_q, col_q, row_q, map_q;
  logic signed [DATA_W-1:0] held_q;
  logic                     out_valid_q, done_q, fin_q;
  logic [DATA_W-1:0]        out_data_q;
  logic signed [LB_W-1:0]   lb_q [LB_N];

  logic signed [DATA_W-1:0] px;
  logic signed [LB_W-1:0]   lb_rd, pair_d;
  logic [DATA_W-1:0]        res_d;
  logic [15:0]              even_lim;
  logic                     fire, in_win, emit, last_col, last_row, last_px;
  logic [IDX_W-1:0]         lb_idx;

  assign px       = in_data;
  assign lb_idx   = col_q[IDX_W:1];
  assign lb_rd    = lb_q[lb_idx];
  assign even_lim = {img_q[15:1], 1'b0};
  assign in_win   = (col_q < even_lim) && (row_q < even_lim);
  assign emit     = in_win && col_q[0] && row_q[0];
  assign last_col = (col_q == img_q - 16'd1);
  assign last_row = (row_q == img_q - 16'd1);
  assign last_px  = last_col && last_row && (map_q == maps_q - 16'd1);

  // fin_q blocks further pixels while the job's final output waits for the sink
  assign in_ready = (state_q == RUN) && !fin_q && !(out_valid_q && !out_ready);
  assign fire     = in_valid && in_ready;

`ifdef POOL_MAX_EN
  logic signed [DATA_W-1:0] max3;
  assign pair_d = (held_q > px) ? held_q : px;
  assign max3   = (lb_rd > pair_d) ? lb_rd : pair_d;
  assign res_d  = max3;
`else
  logic signed [DATA_W+1:0] quad;
  assign pair_d = {held_q[DATA_W-1], held_q} + {px[DATA_W-1], px};
  assign quad   = {lb_rd[LB_W-1], lb_rd} + {{2{held_q[DATA_W-1]}}, held_q}
                + {{2{px[DATA_W-1]}}, px};
  assign res_d  = DATA_W'(quad >>> 2);
`endif

  // Even-row pair sums/maxes; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (fire && in_win && col_q[0] && !row_q[0]) lb_q[lb_idx] <= pair_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      img_q       <= '0;
      maps_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      map_q       <= '0;
      held_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
      fin_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (enable) begin
          img_q  <= imgSize;
          maps_q <= mapsNumber;
          col_q  <= '0;
          row_q  <= '0;
          map_q  <= '0;
          fin_q  <= 1'b0;
          // a zero-sized job has no pixels to wait for
          if (mapsNumber == 16'd0 || imgSize == 16'd0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (out_valid_q && out_ready) out_valid_q <= 1'b0;
          if (fire) begin
            if (last_col) begin
              col_q <= '0;
              if (last_row) begin
                row_q <= '0;
                map_q <= map_q + 16'd1;
              end else begin
                row_q <= row_q + 16'd1;
              end
            end else begin
              col_q <= col_q + 16'd1;
            end
            if (in_win && !col_q[0]) held_q <= px;
            if (emit) begin
              out_valid_q <= 1'b1;
              out_data_q  <= res_d;
            end
            if (last_px) begin
              if (emit) begin
                fin_q <= 1'b1;
              end else begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end
            end
          end else if (fin_q && out_valid_q && out_ready) begin
            fin_q   <= 1'b0;
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: if (!enable) begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign done      = done_q;

endmodule

// File: tb/tb_avg_pool_layer.sv
// Directed bench for avg_pool_layer; expected values are hand-computed for either build.
module tb_avg_pool_layer;

  logic        clk = 1'b0;
  logic        reset, enable, in_valid, out_ready, in_ready, out_valid, done;
  logic [15:0] imgSize, mapsNumber, in_data, out_data;

  int n_chk = 0;
  int n_pass = 0;
  int got[$];
  int exp_q[$];

  avg_pool_layer #(.DATA_W(16), .MAX_IMG(32)) dut (
    .clk(clk), .reset(reset), .enable(enable), .imgSize(imgSize),
    .mapsNumber(mapsNumber), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .done(done)
  );

  always #5 clk = ~clk;

  // a transfer happens at the next rising edge when both are high here
  always @(negedge clk) if (out_valid && out_ready) got.push_back(int'($signed(out_data)));

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic start(input int img, input int maps);
    imgSize = 16'(img); mapsNumber = 16'(maps); enable = 1'b1;
    @(posedge clk); #1;
    got.delete();
  endtask

  task automatic push(input int d);
    int t = 0;
    in_valid = 1'b1; in_data = 16'(d);
    @(negedge clk);
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    if (!in_ready) chk("push_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic finish_job(input string tag);
    int t = 0;
    while (!done && t < 20) begin @(negedge clk); t++; end
    chk({tag, "_done"}, int'(done), 1);
    enable = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_idle"}, int'(done), 0);
  endtask

  task automatic check_got(input string tag);
    chk({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_out%0d", tag, i), (i < got.size()) ? got[i] : -99999, exp_q[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; enable = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b1; imgSize = '0; mapsNumber = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_done", int'(done), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // abort a job with an output pending
    start(4, 1);
    for (int i = 0; i < 6; i++) push(i);
    chk("mid_out_valid", int'(out_valid), 1);
    reset = 1'b0; enable = 1'b0;
    repeat (2) @(posedge clk); #1;
    reset = 1'b1;
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    chk("abort_idle", int'(in_ready), 0);

    // basic 4x4 with latency checks; also the restarted job
    start(4, 1);
    chk("run_in_ready", int'(in_ready), 1);
    for (int i = 0; i < 16; i++) begin
      push(i);
      if (i == 4) chk("lat_pre", int'(out_valid), 0);
      if (i == 5) begin
        chk("lat_valid", int'(out_valid), 1);
`ifdef POOL_MAX_EN
        chk("lat_data", int'($signed(out_data)), 5);
`else
        chk("lat_data", int'($signed(out_data)), 2);
`endif
      end
    end
    finish_job("basic");
`ifdef POOL_MAX_EN
    exp_q = '{5, 7, 13, 15};
`else
    exp_q = '{2, 4, 10, 12};
`endif
    check_got("basic");

    // negative window: floor rounding toward -inf
    start(2, 1);
    for (int i = 1; i <= 4; i++) push(-i);
    finish_job("neg");
`ifdef POOL_MAX_EN
    exp_q = '{-1};
`else
    exp_q = '{-3};
`endif
    check_got("neg");

    // full-scale positive: no overflow in the wide sum
    start(2, 1);
    for (int i = 0; i < 4; i++) push(32767);
    finish_job("sat");
    exp_q = '{32767};
    check_got("sat");

    // 5x5, 3 maps: last row/col discarded
    start(5, 3);
    for (int m = 0; m < 3; m++)
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++) push(100 * m + 5 * r + c);
    chk("odd_done_now", int'(done), 1);
    finish_job("odd");
    exp_q.delete();
    for (int m = 0; m < 3; m++) begin
`ifdef POOL_MAX_EN
      exp_q.push_back(100 * m + 6);  exp_q.push_back(100 * m + 8);
      exp_q.push_back(100 * m + 16); exp_q.push_back(100 * m + 18);
`else
      exp_q.push_back(100 * m + 3);  exp_q.push_back(100 * m + 5);
      exp_q.push_back(100 * m + 13); exp_q.push_back(100 * m + 15);
`endif
    end
    check_got("odd");

    // back-pressure: stall the sink after the first output with a pixel waiting
    start(4, 1);
    for (int i = 0; i < 6; i++) push(i);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'd6;
    repeat (10) @(posedge clk); #1;
    chk("bp_valid", int'(out_valid), 1);
`ifdef POOL_MAX_EN
    chk("bp_data", int'($signed(out_data)), 5);
`else
    chk("bp_data", int'($signed(out_data)), 2);
`endif
    chk("bp_in_ready", int'(in_ready), 0);
    out_ready = 1'b1;
    for (int i = 6; i < 16; i++) push(i);
    finish_job("bp");
`ifdef POOL_MAX_EN
    exp_q = '{5, 7, 13, 15};
`else
    exp_q = '{2, 4, 10, 12};
`endif
    check_got("bp");

    // zero maps goes straight to DONE
    start(4, 0);
    chk("zero_done", int'(done), 1);
    finish_job("zero");

    // 1x1 maps: accepted and dropped
    start(1, 2);
    push(7); push(8);
    finish_job("tiny");
    exp_q.delete();
    check_got("tiny");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
